// File: rtl/num_entry.sv
// Keypad-to-operand stage: accumulates BCD key codes into a num_t and hands it to the ALU.
// Latency: key effect visible on disp_o one cycle after acceptance; operand valid one cycle after ENTER.
// Backpressure: key_ready_o drops while an operand waits in HOLD; num_valid_o holds until num_ready_i.

package calc_pkg;
    localparam int NumDigits = 8;
    localparam int ExpWidth  = 8;

    typedef struct packed {
        logic                       error;
        logic                       sign;
        logic signed [ExpWidth-1:0] exponent;
        logic [NumDigits-1:0][3:0]  sig;
    } num_t;
endpackage

module num_entry #(
    parameter int NumDigits = calc_pkg::NumDigits
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               key_valid_i,
    output logic                               key_ready_o,
    input  logic [3:0]                         key_code_i,
    output logic                               num_valid_o,
    input  logic                               num_ready_i,
    output calc_pkg::num_t                     num_o,
    output calc_pkg::num_t                     disp_o,
    output logic [$clog2(NumDigits):0]         digit_count_o,
    output logic                               overflow_o
);

    localparam int CntW = $clog2(NumDigits) + 1;

    localparam logic [3:0] KeyNeg   = 4'd10;
    localparam logic [3:0] KeyBksp  = 4'd11;
    localparam logic [3:0] KeyClr   = 4'd12;
    localparam logic [3:0] KeyEnter = 4'd13;

    if (NumDigits != calc_pkg::NumDigits) begin : g_bad_num_digits
        $error("num_entry: NumDigits must equal calc_pkg::NumDigits");
    end

    typedef enum logic {ENTRY, HOLD} state_t;

    state_t            state_q;
    state_t            state_nxt;
    calc_pkg::num_t    entry_q;
    calc_pkg::num_t    num_q;
    calc_pkg::num_t    commit;
    logic [CntW-1:0]   count_q;
    logic              ovf_q;
    logic              key_acc;

    assign key_acc = key_valid_i && (state_q == ENTRY);

    // A zero significand is always committed as +0 so the ALU never sees -0.
    always_comb begin
        commit      = '0;
        commit.sig  = entry_q.sig;
        commit.sign = entry_q.sign && (entry_q.sig != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ENTRY;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ENTRY: if (key_acc && key_code_i == KeyEnter) state_nxt = HOLD;
            HOLD:  if (num_ready_i) state_nxt = ENTRY;
            default: state_nxt = ENTRY;
        endcase
    end

    always_comb begin
        key_ready_o = (state_q == ENTRY);
        num_valid_o = (state_q == HOLD);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
            num_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (state_q == HOLD) begin
                if (num_ready_i) begin
                    entry_q <= '0;
                    count_q <= '0;
                end
            end else if (key_acc) begin
                if (key_code_i < KeyNeg) begin
                    if (count_q == CntW'(NumDigits)) begin
                        ovf_q <= 1'b1;
                    end else if (!(count_q == '0 && key_code_i == 4'd0)) begin
                        entry_q.sig <= {entry_q.sig[NumDigits-2:0], key_code_i};
                        count_q     <= count_q + CntW'(1);
                    end
                end else begin
                    case (key_code_i)
                        KeyNeg: entry_q.sign <= ~entry_q.sign;
                        KeyBksp: begin
                            if (count_q != '0) begin
                                entry_q.sig <= {4'h0, entry_q.sig[NumDigits-1:1]};
                                count_q     <= count_q - CntW'(1);
                                if (count_q == CntW'(1)) entry_q.sign <= 1'b0;
                            end
                        end
                        KeyClr: begin
                            entry_q <= '0;
                            count_q <= '0;
                        end
                        KeyEnter: num_q <= commit;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign num_o         = num_q;
    assign disp_o        = entry_q;
    assign digit_count_o = count_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_num_entry.sv
// Directed bench for num_entry: key sequences with hand-computed operands.
module tb_num_entry;

    logic           clk;
    logic           rst;
    logic           key_valid;
    logic           key_ready;
    logic [3:0]     key_code;
    logic           num_valid;
    logic           num_ready;
    calc_pkg::num_t num;
    calc_pkg::num_t disp;
    logic [3:0]     digit_count;
    logic           overflow;

    int total = 0;
    int bad   = 0;

    num_entry #(.NumDigits(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .key_valid_i  (key_valid),
        .key_ready_o  (key_ready),
        .key_code_i   (key_code),
        .num_valid_o  (num_valid),
        .num_ready_i  (num_ready),
        .num_o        (num),
        .disp_o       (disp),
        .digit_count_o(digit_count),
        .overflow_o   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic calc_pkg::num_t mk(input logic s, input logic [31:0] sig);
        calc_pkg::num_t n;
        n      = '0;
        n.sign = s;
        n.sig  = sig;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one key for one cycle; returns at the negedge after the accepting edge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        num_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_key_ready", 64'(key_ready), 64'd1);
        chk("rst_num_valid", 64'(num_valid), 64'd0);
        chk("rst_disp", 64'(disp), 64'(mk(1'b0, 32'h0)));
        chk("rst_num", 64'(num), 64'(mk(1'b0, 32'h0)));
        chk("rst_count", 64'(digit_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // 1,2,3,ENTER with ready held high
        press(4'd1); press(4'd2); press(4'd3);
        chk("p123_disp", 64'(disp), 64'(mk(1'b0, 32'h123)));
        chk("p123_count", 64'(digit_count), 64'd3);
        press(4'd13);
        chk("p123_valid", 64'(num_valid), 64'd1);
        chk("p123_key_ready", 64'(key_ready), 64'd0);
        chk("p123_num", 64'(num), 64'(mk(1'b0, 32'h123)));
        @(negedge clk);
        chk("p123_valid_drop", 64'(num_valid), 64'd0);
        chk("p123_ready_back", 64'(key_ready), 64'd1);
        chk("p123_disp_clear", 64'(disp), 64'(mk(1'b0, 32'h0)));

        // leading zeros then negate
        press(4'd0); press(4'd0);
        chk("lz_count0", 64'(digit_count), 64'd0);
        press(4'd5);
        chk("lz_count1", 64'(digit_count), 64'd1);
        press(4'd10);
        chk("lz_disp_neg", 64'(disp), 64'(mk(1'b1, 32'h5)));
        press(4'd13);
        chk("lz_num", 64'(num), 64'(mk(1'b1, 32'h5)));
        @(negedge clk);

        // negative zero is committed as +0
        press(4'd10);
        chk("nz_disp", 64'(disp), 64'(mk(1'b1, 32'h0)));
        press(4'd13);
        chk("nz_num", 64'(num), 64'(mk(1'b0, 32'h0)));
        @(negedge clk);

        // overflow on ninth digit
        repeat (8) press(4'd9);
        chk("ov_count8", 64'(digit_count), 64'd8);
        chk("ov_no_pulse", 64'(overflow), 64'd0);
        press(4'd9);
        chk("ov_pulse", 64'(overflow), 64'd1);
        chk("ov_disp", 64'(disp), 64'(mk(1'b0, 32'h99999999)));
        @(negedge clk);
        chk("ov_pulse_end", 64'(overflow), 64'd0);
        press(4'd13);
        chk("ov_num", 64'(num), 64'(mk(1'b0, 32'h99999999)));
        @(negedge clk);

        // backspace sequence with sign
        press(4'd4); press(4'd10);
        chk("bk_m4", 64'(disp), 64'(mk(1'b1, 32'h4)));
        press(4'd7);
        chk("bk_m47", 64'(disp), 64'(mk(1'b1, 32'h47)));
        press(4'd11);
        chk("bk_m4_again", 64'(disp), 64'(mk(1'b1, 32'h4)));
        press(4'd11);
        chk("bk_zero", 64'(disp), 64'(mk(1'b0, 32'h0)));
        chk("bk_count0", 64'(digit_count), 64'd0);
        press(4'd11);
        chk("bk_noop", 64'(disp), 64'(mk(1'b0, 32'h0)));
        chk("bk_noop_count", 64'(digit_count), 64'd0);

        // ignored codes and clear
        press(4'd6); press(4'd14); press(4'd15);
        chk("ign_disp", 64'(disp), 64'(mk(1'b0, 32'h6)));
        chk("ign_count", 64'(digit_count), 64'd1);
        press(4'd12);
        chk("clr_disp", 64'(disp), 64'(mk(1'b0, 32'h0)));
        chk("clr_count", 64'(digit_count), 64'd0);

        // ENTER while ALU stalls for 5 cycles; offered keys must be dropped
        press(4'd3);
        num_ready = 1'b0;
        press(4'd13);
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1;
            key_code  = 4'd8;
            @(negedge clk);
            chk("st_valid", 64'(num_valid), 64'd1);
            chk("st_key_ready", 64'(key_ready), 64'd0);
            chk("st_num", 64'(num), 64'(mk(1'b0, 32'h3)));
            chk("st_disp", 64'(disp), 64'(mk(1'b0, 32'h3)));
        end
        key_valid = 1'b0;
        num_ready = 1'b1;
        @(negedge clk);
        chk("st_released", 64'(num_valid), 64'd0);
        chk("st_disp_clear", 64'(disp), 64'(mk(1'b0, 32'h0)));
        chk("st_count_clear", 64'(digit_count), 64'd0);

        // reset while holding an operand
        press(4'd2);
        num_ready = 1'b0;
        press(4'd13);
        chk("rh_valid", 64'(num_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        num_ready = 1'b1;
        chk("rh_valid_drop", 64'(num_valid), 64'd0);
        chk("rh_disp", 64'(disp), 64'(mk(1'b0, 32'h0)));
        chk("rh_key_ready", 64'(key_ready), 64'd1);
        chk("rh_num", 64'(num), 64'(mk(1'b0, 32'h0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
